// File: rtl/proc_pkg.sv
// Shared definitions for the proc instruction sequencer: opcodes, field positions
// of the 16-bit instruction word, and the sequencer FSM state type.
package proc_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int A_MSB  = 11;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 4;
  localparam int C_MSB  = 3;
  localparam int C_LSB  = 0;

  localparam logic [3:0] OP_HALT  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_PRINT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_COMPLETE,
    S_HALTED
  } seq_state_e;

  function automatic logic [3:0] op_of(input logic [INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: 2**AW words, synchronous write, asynchronous read so FETCH
// sees the addressed word in the same cycle.
module prog_mem #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_sequencer.sv
// Autonomous initiator for the multicycle proc core: fetches words from a
// loadable store, runs them one at a time over Run/Done and captures PRINT
// results. Define PROC_SEQ_TIMEOUT_EN to enable the ISSUE timeout / Error flag.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int AW          = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               LoadEn,
  input  logic [AW-1:0]      LoadAddr,
  input  logic [INSTR_W-1:0] LoadData,
  input  logic               Start,
  output logic [INSTR_W-1:0] ProcInput,
  output logic               ProcRun,
  input  logic               ProcDone,
  input  logic [INSTR_W-1:0] ProcOutput,
  output logic [INSTR_W-1:0] Result,
  output logic               ResultValid,
  output logic               Busy,
  output logic               Finished,
  output logic [AW-1:0]      Pc,
  output logic               Error
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("proc_sequencer: TIMEOUT_CYC must be at least 1");
  end

  seq_state_e         state, state_nxt;
  logic [INSTR_W-1:0] rd_word;
  logic               wr_en;
  logic               done_q;
  logic               done_rise;
  logic               last_pc;
  logic               timeout;

  // Writes are only accepted while nothing is executing.
  assign wr_en = LoadEn && (state == S_IDLE || state == S_HALTED);

  prog_mem #(
    .AW (AW),
    .DW (INSTR_W)
  ) u_mem (
    .clk   (Clock),
    .we    (wr_en),
    .waddr (LoadAddr),
    .wdata (LoadData),
    .raddr (Pc),
    .rdata (rd_word)
  );

  // A Done level already high when ISSUE is entered must not complete it.
  assign done_rise = ProcDone && !done_q;
  assign last_pc   = (Pc == {AW{1'b1}});

`ifdef PROC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  always_ff @(posedge Clock) begin
    if (Reset)                 wait_cnt <= '0;
    else if (state != S_ISSUE) wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout = (state == S_ISSUE) && !done_rise &&
                   (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge Clock) begin
    if (Reset)        err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign Error = err_q;
`else
  assign timeout = 1'b0;
  assign Error   = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (Start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = (op_of(rd_word) == OP_HALT) ? S_HALTED : S_ISSUE;
      S_ISSUE: begin
        if (done_rise)    state_nxt = S_COMPLETE;
        else if (timeout) state_nxt = S_HALTED;
      end
      S_COMPLETE: state_nxt = last_pc ? S_HALTED : S_FETCH;
      S_HALTED:   if (Start) state_nxt = S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ProcRun  = 1'b0;
    Busy     = 1'b0;
    Finished = 1'b0;
    unique case (state)
      S_FETCH, S_COMPLETE: Busy = 1'b1;
      S_ISSUE: begin
        Busy    = 1'b1;
        ProcRun = 1'b1;
      end
      S_HALTED: Finished = 1'b1;
      default: ;
    endcase
  end

  // ProcInput holds the issued word through COMPLETE so its opcode selects capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Pc          <= '0;
      ProcInput   <= '0;
      Result      <= '0;
      ResultValid <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= ProcDone;
      ResultValid <= 1'b0;
      unique case (state)
        S_IDLE, S_HALTED: if (Start) Pc <= '0;
        S_FETCH: if (op_of(rd_word) != OP_HALT) ProcInput <= rd_word;
        S_COMPLETE: begin
          if (op_of(ProcInput) == OP_PRINT) begin
            Result      <= ProcOutput;
            ResultValid <= 1'b1;
          end
          if (!last_pc) Pc <= Pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
